// File: rtl/regfile_port_arbiter_pkg.sv
// Shared types and constants for the regfile debug-port arbiter.
// Optional writeback bypass is selected by RF_WB_BYPASS_EN (see regfile_port_arbiter.sv).
package rf_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ZERO_REG   = 0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_t;

  // Counter width able to hold 0..max; a zero max still needs one bit.
  function automatic int unsigned ctr_width(input int unsigned max);
    return (max > 0) ? $clog2(max + 1) : 1;
  endfunction

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Bus bundle between CPU decode, display sequencer, regfile and the arbiter.
// master = system side (requesters + regfile), slave = arbiter.
interface regfile_port_arbiter_if
  import rf_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_raddr;
  logic              cpu_stall;

  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_raddr;
  logic              dbg_ack;
  logic              dbg_rvalid;
  logic              dbg_rready;
  logic [DATA_W-1:0] dbg_rdata;

  logic [ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport master (
    output cpu_req, cpu_raddr,
    output dbg_req, dbg_raddr, dbg_rready,
    output rf_rdata, rf_we, rf_waddr, rf_wdata,
    input  cpu_stall, dbg_ack, dbg_rvalid, dbg_rdata, rf_raddr
  );

  modport slave (
    input  cpu_req, cpu_raddr,
    input  dbg_req, dbg_raddr, dbg_rready,
    input  rf_rdata, rf_we, rf_waddr, rf_wdata,
    output cpu_stall, dbg_ack, dbg_rvalid, dbg_rdata, rf_raddr
  );

endinterface

// File: rtl/regfile_port_arbiter_starve_ctr.sv
// Saturating starvation counter for the debug requester; at_max flags a forced grant.
module rf_starve_ctr
  import rf_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned CW = ctr_width(STARVE_MAX);
  localparam logic [CW-1:0] MAX_V = CW'(STARVE_MAX);

  logic [CW-1:0] cnt;

  assign at_max = (cnt == MAX_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Arbitrates the regfile debug read port between CPU decode and the display requester.
// Define RF_WB_BYPASS_EN to forward a same-cycle writeback into the debug response.
module regfile_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = 15
) (
  input logic                   clk,
  input logic                   rst_n,
  regfile_port_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  arb_state_t        state, state_nxt;
  logic              grant;
  logic              at_max;
  logic              cnt_inc;
  logic              cnt_clr;
  logic              handshake;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] capture;

  always_comb begin
    grant     = (state == IDLE) && bus.dbg_req && (!bus.cpu_req || at_max);
    handshake = (state == RESP) && bus.dbg_rready;
    cnt_inc   = (state == IDLE) && bus.dbg_req && !grant;
    cnt_clr   = grant || !bus.dbg_req;
  end

  assign bus.dbg_ack    = grant;
  assign bus.cpu_stall  = grant && bus.cpu_req;
  assign bus.rf_raddr   = grant ? bus.dbg_raddr : bus.cpu_raddr;
  assign bus.dbg_rvalid = (state == RESP);
  assign bus.dbg_rdata  = rdata_q;

  rf_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (cnt_inc),
    .clr    (cnt_clr),
    .at_max (at_max)
  );

`ifdef RF_WB_BYPASS_EN
  always_comb begin
    capture = bus.rf_rdata;
    if (bus.dbg_raddr == ZERO_ADDR) begin
      capture = '0;
    end else if (bus.rf_we && (bus.rf_waddr == bus.dbg_raddr)) begin
      capture = bus.rf_wdata;
    end
  end
`else
  // Writeback snoop ports are part of the bus but carry no meaning here.
  logic unused_wb;
  assign unused_wb = ^{bus.rf_we, bus.rf_waddr, bus.rf_wdata};

  always_comb begin
    capture = bus.rf_rdata;
    if (bus.dbg_raddr == ZERO_ADDR) begin
      capture = '0;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant)     state_nxt = RESP;
      RESP:    if (handshake) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Only written on grant, so the value persists after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (grant) begin
      rdata_q <= capture;
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter; inputs change 1ns after posedge, outputs sampled on negedge.
module tb_regfile_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  regfile_port_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  regfile_port_arbiter #(
    .ADDR_W     (5),
    .DATA_W     (32),
    .STARVE_MAX (15)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  task automatic drive_idle();
    bus.cpu_req    = 1'b0;
    bus.cpu_raddr  = 5'd0;
    bus.dbg_req    = 1'b0;
    bus.dbg_raddr  = 5'd0;
    bus.dbg_rready = 1'b0;
    bus.rf_rdata   = 32'h0;
    bus.rf_we      = 1'b0;
    bus.rf_waddr   = 5'd0;
    bus.rf_wdata   = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    bus.cpu_raddr = 5'd3;
    bus.dbg_raddr = 5'd6;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (bus.dbg_rvalid !== 1'b0) begin miscompares++; $display("FAIL rst_rvalid: got %b expected 0", bus.dbg_rvalid); end
    vectors++; if (bus.dbg_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata: got %h expected 0", bus.dbg_rdata); end
    vectors++; if (bus.dbg_ack !== 1'b0) begin miscompares++; $display("FAIL rst_ack: got %b expected 0", bus.dbg_ack); end
    vectors++; if (bus.cpu_stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall: got %b expected 0", bus.cpu_stall); end
    vectors++; if (bus.rf_raddr !== 5'd3) begin miscompares++; $display("FAIL rst_raddr: got %0d expected 3", bus.rf_raddr); end
    #1 bus.dbg_req = 1'b1;
    #1;
    vectors++; if (bus.dbg_ack !== 1'b1) begin miscompares++; $display("FAIL rst_ack_eq: got %b expected 1", bus.dbg_ack); end
    vectors++; if (bus.rf_raddr !== 5'd6) begin miscompares++; $display("FAIL rst_raddr_eq: got %0d expected 6", bus.rf_raddr); end
    @(posedge clk); #1;
    vectors++; if (bus.dbg_rvalid !== 1'b0) begin miscompares++; $display("FAIL rst_hold_rvalid: got %b expected 0", bus.dbg_rvalid); end
    bus.dbg_req = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_grant();
    bus.dbg_req   = 1'b1;
    bus.dbg_raddr = 5'd6;
    bus.rf_rdata  = 32'h0000_3039;
    @(negedge clk);
    vectors++; if (bus.dbg_ack !== 1'b1) begin miscompares++; $display("FAIL idle_ack: got %b expected 1", bus.dbg_ack); end
    vectors++; if (bus.cpu_stall !== 1'b0) begin miscompares++; $display("FAIL idle_stall: got %b expected 0", bus.cpu_stall); end
    vectors++; if (bus.rf_raddr !== 5'd6) begin miscompares++; $display("FAIL idle_raddr: got %0d expected 6", bus.rf_raddr); end
    @(posedge clk); #1;
    bus.dbg_req  = 1'b0;
    bus.rf_rdata = 32'h0000_9999;
    @(negedge clk);
    vectors++; if (bus.dbg_rvalid !== 1'b1) begin miscompares++; $display("FAIL idle_rvalid: got %b expected 1", bus.dbg_rvalid); end
    vectors++; if (bus.dbg_rdata !== 32'h0000_3039) begin miscompares++; $display("FAIL idle_rdata: got %h expected 00003039", bus.dbg_rdata); end
    vectors++; if (bus.dbg_ack !== 1'b0) begin miscompares++; $display("FAIL idle_ack_drop: got %b expected 0", bus.dbg_ack); end
    bus.dbg_rready = 1'b1;
    @(posedge clk); #1;
    bus.dbg_rready = 1'b0;
    @(negedge clk);
    vectors++; if (bus.dbg_rvalid !== 1'b0) begin miscompares++; $display("FAIL idle_rvalid_drop: got %b expected 0", bus.dbg_rvalid); end
    vectors++; if (bus.dbg_rdata !== 32'h0000_3039) begin miscompares++; $display("FAIL idle_rdata_keep: got %h expected 00003039", bus.dbg_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_starvation();
    int blocked = 0;
    bit granted = 1'b0;
    bus.cpu_req   = 1'b1;
    bus.cpu_raddr = 5'd9;
    bus.dbg_req   = 1'b1;
    bus.dbg_raddr = 5'd7;
    bus.rf_rdata  = 32'h0000_0055;
    for (int i = 0; i < 40 && !granted; i++) begin
      @(negedge clk);
      if (bus.dbg_ack === 1'b1) begin
        granted = 1'b1;
        vectors++; if (bus.cpu_stall !== 1'b1) begin miscompares++; $display("FAIL starve_stall: got %b expected 1", bus.cpu_stall); end
        vectors++; if (bus.rf_raddr !== 5'd7) begin miscompares++; $display("FAIL starve_raddr: got %0d expected 7", bus.rf_raddr); end
      end else begin
        blocked++;
        vectors++; if (bus.cpu_stall !== 1'b0) begin miscompares++; $display("FAIL starve_blocked_stall: got %b expected 0", bus.cpu_stall); end
      end
      @(posedge clk); #1;
    end
    vectors++; if (!granted) begin miscompares++; $display("FAIL starve_timeout: got no grant expected grant within 40 cycles"); end
    vectors++; if (blocked !== 15) begin miscompares++; $display("FAIL starve_blocked: got %0d expected 15", blocked); end
    bus.dbg_req    = 1'b0;
    bus.dbg_rready = 1'b1;
    @(negedge clk);
    vectors++; if (bus.cpu_stall !== 1'b0) begin miscompares++; $display("FAIL starve_stall_once: got %b expected 0", bus.cpu_stall); end
    vectors++; if (bus.rf_raddr !== 5'd9) begin miscompares++; $display("FAIL starve_raddr_back: got %0d expected 9", bus.rf_raddr); end
    vectors++; if (bus.dbg_rdata !== 32'h0000_0055) begin miscompares++; $display("FAIL starve_rdata: got %h expected 00000055", bus.dbg_rdata); end
    @(posedge clk); #1;
    bus.dbg_rready = 1'b0;
    bus.cpu_req    = 1'b0;
  endtask

  task automatic test_zero_reg();
    bus.dbg_req   = 1'b1;
    bus.dbg_raddr = 5'd0;
    bus.rf_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    vectors++; if (bus.dbg_ack !== 1'b1) begin miscompares++; $display("FAIL zero_ack: got %b expected 1", bus.dbg_ack); end
    @(posedge clk); #1;
    bus.dbg_req = 1'b0;
    @(negedge clk);
    vectors++; if (bus.dbg_rdata !== 32'h0) begin miscompares++; $display("FAIL zero_rdata: got %h expected 00000000", bus.dbg_rdata); end
    bus.dbg_rready = 1'b1;
    @(posedge clk); #1;
    bus.dbg_rready = 1'b0;
  endtask

  task automatic test_backpressure();
    bus.dbg_req   = 1'b1;
    bus.dbg_raddr = 5'd5;
    bus.rf_rdata  = 32'h0000_A5A5;
    @(negedge clk);
    vectors++; if (bus.dbg_ack !== 1'b1) begin miscompares++; $display("FAIL bp_ack: got %b expected 1", bus.dbg_ack); end
    @(posedge clk); #1;
    bus.dbg_raddr = 5'd8;
    bus.rf_rdata  = 32'h0000_1111;
    bus.cpu_req   = 1'b1;
    bus.cpu_raddr = 5'd12;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++; if (bus.dbg_rvalid !== 1'b1) begin miscompares++; $display("FAIL bp_rvalid[%0d]: got %b expected 1", i, bus.dbg_rvalid); end
      vectors++; if (bus.dbg_rdata !== 32'h0000_A5A5) begin miscompares++; $display("FAIL bp_rdata[%0d]: got %h expected 0000a5a5", i, bus.dbg_rdata); end
      vectors++; if (bus.dbg_ack !== 1'b0) begin miscompares++; $display("FAIL bp_ack2[%0d]: got %b expected 0", i, bus.dbg_ack); end
      vectors++; if (bus.cpu_stall !== 1'b0) begin miscompares++; $display("FAIL bp_stall[%0d]: got %b expected 0", i, bus.cpu_stall); end
      vectors++; if (bus.rf_raddr !== 5'd12) begin miscompares++; $display("FAIL bp_raddr[%0d]: got %0d expected 12", i, bus.rf_raddr); end
      @(posedge clk); #1;
    end
    bus.cpu_req    = 1'b0;
    bus.dbg_rready = 1'b1;
    @(negedge clk);
    vectors++; if (bus.dbg_ack !== 1'b0) begin miscompares++; $display("FAIL bp_hs_ack: got %b expected 0", bus.dbg_ack); end
    @(posedge clk); #1;
    bus.dbg_rready = 1'b0;
    @(negedge clk);
    vectors++; if (bus.dbg_ack !== 1'b1) begin miscompares++; $display("FAIL bp_next_ack: got %b expected 1", bus.dbg_ack); end
    vectors++; if (bus.rf_raddr !== 5'd8) begin miscompares++; $display("FAIL bp_next_raddr: got %0d expected 8", bus.rf_raddr); end
    vectors++; if (bus.dbg_rvalid !== 1'b0) begin miscompares++; $display("FAIL bp_next_rvalid: got %b expected 0", bus.dbg_rvalid); end
    @(posedge clk); #1;
    bus.dbg_req = 1'b0;
    @(negedge clk);
    vectors++; if (bus.dbg_rdata !== 32'h0000_1111) begin miscompares++; $display("FAIL bp_next_rdata: got %h expected 00001111", bus.dbg_rdata); end
    bus.dbg_rready = 1'b1;
    @(posedge clk); #1;
    bus.dbg_rready = 1'b0;
  endtask

  task automatic test_wb_bypass();
    logic [31:0] exp_data;
`ifdef RF_WB_BYPASS_EN
    exp_data = 32'h0000_1234;
`else
    exp_data = 32'h0000_3039;
`endif
    bus.dbg_req   = 1'b1;
    bus.dbg_raddr = 5'd6;
    bus.rf_rdata  = 32'h0000_3039;
    bus.rf_we     = 1'b1;
    bus.rf_waddr  = 5'd6;
    bus.rf_wdata  = 32'h0000_1234;
    @(negedge clk);
    vectors++; if (bus.dbg_ack !== 1'b1) begin miscompares++; $display("FAIL wb_ack: got %b expected 1", bus.dbg_ack); end
    @(posedge clk); #1;
    bus.dbg_req = 1'b0;
    bus.rf_we   = 1'b0;
    @(negedge clk);
    vectors++; if (bus.dbg_rdata !== exp_data) begin miscompares++; $display("FAIL wb_rdata: got %h expected %h", bus.dbg_rdata, exp_data); end
    bus.dbg_rready = 1'b1;
    @(posedge clk); #1;
    bus.dbg_rready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int blocked = 0;
    bit granted = 1'b0;
    bus.dbg_req   = 1'b1;
    bus.dbg_raddr = 5'd6;
    bus.rf_rdata  = 32'h0000_3039;
    @(posedge clk); #1;
    bus.dbg_req = 1'b0;
    vectors++; if (bus.dbg_rvalid !== 1'b1) begin miscompares++; $display("FAIL rm_pre_rvalid: got %b expected 1", bus.dbg_rvalid); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (bus.dbg_rvalid !== 1'b0) begin miscompares++; $display("FAIL rm_rvalid: got %b expected 0", bus.dbg_rvalid); end
    vectors++; if (bus.dbg_rdata !== 32'h0) begin miscompares++; $display("FAIL rm_rdata: got %h expected 00000000", bus.dbg_rdata); end
    bus.dbg_req   = 1'b1;
    bus.dbg_raddr = 5'd2;
    #1;
    vectors++; if (bus.dbg_ack !== 1'b1) begin miscompares++; $display("FAIL rm_idle_ack: got %b expected 1", bus.dbg_ack); end
    bus.dbg_req = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (bus.dbg_ack !== 1'b0) begin miscompares++; $display("FAIL rm_no_replay: got %b expected 0", bus.dbg_ack); end
    vectors++; if (bus.dbg_rvalid !== 1'b0) begin miscompares++; $display("FAIL rm_post_rvalid: got %b expected 0", bus.dbg_rvalid); end
    @(posedge clk); #1;
    // Build up starvation, then reset: the full window must restart.
    bus.cpu_req   = 1'b1;
    bus.cpu_raddr = 5'd9;
    bus.dbg_req   = 1'b1;
    bus.dbg_raddr = 5'd7;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 40 && !granted; i++) begin
      @(negedge clk);
      if (bus.dbg_ack === 1'b1) granted = 1'b1;
      else blocked++;
      @(posedge clk); #1;
    end
    vectors++; if (!granted) begin miscompares++; $display("FAIL rm_timeout: got no grant expected grant within 40 cycles"); end
    vectors++; if (blocked !== 15) begin miscompares++; $display("FAIL rm_ctr_clear: got %0d blocked expected 15", blocked); end
    bus.dbg_req    = 1'b0;
    bus.dbg_rready = 1'b1;
    @(posedge clk); #1;
    bus.dbg_rready = 1'b0;
    bus.cpu_req    = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_grant();
    test_starvation();
    test_zero_reg();
    test_backpressure();
    test_wb_bypass();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
